// File: rtl/cellrv32_package.sv
// Slice of the shared cellrv32 package: the remapped vector instruction record
// passed from the remap stage to the issuing stage, plus the default depth of
// the decoupling queue between them.
package cellrv32_package;

  // Default depth of the remap -> issue decoupling queue.
  localparam int vis_queue_depth_c = 4;

  // Remapped vector instruction as produced by the remap stage.
  typedef struct packed {
    logic [6:0]  fu;          // functional-unit / opcode selector
    logic [4:0]  dst;         // remapped destination register
    logic [4:0]  src1;        // remapped source 1
    logic [4:0]  src2;        // remapped source 2
    logic [7:0]  vl;          // vector length for this instruction
    logic        reconfigure; // vsetvl-style reconfigure; ordering enforced downstream
    logic [31:0] data1;       // scalar operand
  } remapped_v_instr;

endpackage

// File: rtl/vis_instr_queue.sv
// vis_instr_queue: decoupling FIFO between the vector remap stage and the
// vector issuing stage. The oldest entry is presented on valid_o/instr_o and
// held stable until the issuing stage pops it, however many cycles it spends
// expanding that instruction into micro-ops.
//
// Ports:
//   clk_i, rstn_i        clock, asynchronous active-low reset
//   flush_i              synchronous clear of all entries (wins over push/pop)
//   valid_i, instr_i     upstream instruction; accepted when ready_o is high
//   ready_o              queue can accept this cycle (registered: ~full)
//   valid_o, instr_o     head entry toward the issuing stage
//   ready_i              issuing stage pops the head
//   count_o              occupancy
//   empty_o, full_o      occupancy decodes
module vis_instr_queue
  import cellrv32_package::*;
#(
  parameter int DEPTH = vis_queue_depth_c
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic                       flush_i,
  input  logic                       valid_i,
  input  remapped_v_instr            instr_i,
  output logic                       ready_o,
  output logic                       valid_o,
  output remapped_v_instr            instr_o,
  input  logic                       ready_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       empty_o,
  output logic                       full_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  remapped_v_instr mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            push, pop;

  // All handshake outputs decode from the count register only, so nothing
  // from the issuing stage reaches ready_o combinationally. A full queue
  // therefore cannot accept in the same cycle it is popped.
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign ready_o = ~full_o;
  assign valid_o = ~empty_o;
  assign count_o = count_q;
  assign instr_o = mem_q[rd_ptr_q];

  assign push = valid_i & ready_o;
  assign pop  = valid_o & ready_i;

  // Pointers are exactly log2(DEPTH) bits, so wrap is the natural overflow.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is cleared on reset so instr_o is deterministic while empty.
  // A flush does not need to touch it: the pointers and count hide old data.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push && !flush_i) begin
      mem_q[wr_ptr_q] <= instr_i;
    end
  end

endmodule

// File: tb/tb_vis_instr_queue.sv
// Directed bench for vis_instr_queue: reset, single entry hold, fill with
// backpressure, simultaneous push/pop with pointer wrap, flush priority and
// asynchronous reset mid-stream.
module tb_vis_instr_queue;
  import cellrv32_package::*;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);

  logic            clk_i = 1'b0;
  logic            rstn_i;
  logic            flush_i;
  logic            valid_i;
  remapped_v_instr instr_i;
  logic            ready_o;
  logic            valid_o;
  remapped_v_instr instr_o;
  logic            ready_i;
  logic [CW-1:0]   count_o;
  logic            empty_o;
  logic            full_o;

  int checks   = 0;
  int failures = 0;

  vis_instr_queue #(.DEPTH(DEPTH)) dut (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .flush_i (flush_i),
    .valid_i (valid_i),
    .instr_i (instr_i),
    .ready_o (ready_o),
    .valid_o (valid_o),
    .instr_o (instr_o),
    .ready_i (ready_i),
    .count_o (count_o),
    .empty_o (empty_o),
    .full_o  (full_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs set afterwards are captured at the next edge,
  // and outputs read afterwards reflect state after this edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] dst, input logic [7:0] vl);
    valid_i     = v;
    instr_i     = '0;
    instr_i.dst = dst;
    instr_i.vl  = vl;
    instr_i.fu  = 7'(dst) ^ 7'h2a;
  endtask

  initial begin
    rstn_i  = 1'b0;
    flush_i = 1'b0;
    ready_i = 1'b0;
    drive(1'b0, 5'd0, 8'd0);

    // Reset then idle
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_valid_o", 32'(valid_o), 32'd0);
    chk("rst_ready_o", 32'(ready_o), 32'd1);
    chk("rst_count_o", 32'(count_o), 32'd0);
    chk("rst_empty_o", 32'(empty_o), 32'd1);
    chk("rst_full_o",  32'(full_o),  32'd0);
    chk("rst_instr_o", 32'(instr_o.dst), 32'd0);
    rstn_i = 1'b1;
    step();

    // Single instruction held across a multi-cycle expansion
    drive(1'b1, 5'd5, 8'd16);
    step();
    drive(1'b0, 5'd0, 8'd0);
    chk("single_valid", 32'(valid_o), 32'd1);
    chk("single_dst",   32'(instr_o.dst), 32'd5);
    chk("single_vl",    32'(instr_o.vl), 32'd16);
    chk("single_count", 32'(count_o), 32'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("hold_valid", 32'(valid_o), 32'd1);
      chk("hold_dst",   32'(instr_o.dst), 32'd5);
    end
    ready_i = 1'b1;
    step();
    ready_i = 1'b0;
    chk("single_pop_empty", 32'(empty_o), 32'd1);
    chk("single_pop_valid", 32'(valid_o), 32'd0);

    // Fill and backpressure
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, 5'(k), 8'd8);
      step();
    end
    chk("fill_full",    32'(full_o),  32'd1);
    chk("fill_ready",   32'(ready_o), 32'd0);
    chk("fill_count",   32'(count_o), 32'd4);
    drive(1'b1, 5'd5, 8'd8);            // upstream holds the 5th
    step();
    chk("bp_count",     32'(count_o), 32'd4);
    chk("bp_head",      32'(instr_o.dst), 32'd1);
    ready_i = 1'b1;                     // pop while full: no same-cycle accept
    step();
    ready_i = 1'b0;
    chk("bp_pop_count", 32'(count_o), 32'd3);
    chk("bp_pop_ready", 32'(ready_o), 32'd1);
    chk("bp_pop_head",  32'(instr_o.dst), 32'd2);
    step();                             // 5th accepted now
    drive(1'b0, 5'd0, 8'd0);
    chk("bp_acc_count", 32'(count_o), 32'd4);
    ready_i = 1'b1;
    for (int e = 2; e <= 5; e++) begin
      chk("fill_order_valid", 32'(valid_o), 32'd1);
      chk("fill_order_dst",   32'(instr_o.dst), 32'(e));
      step();
    end
    ready_i = 1'b0;
    chk("fill_drain_empty", 32'(empty_o), 32'd1);

    // Simultaneous push/pop at count 2; 8 cycles wraps both pointers twice
    drive(1'b1, 5'd10, 8'd1); step();
    drive(1'b1, 5'd11, 8'd1); step();
    chk("sim_pre_count", 32'(count_o), 32'd2);
    ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 5'(12 + i), 8'd1);
      chk("sim_head",  32'(instr_o.dst), 32'(10 + i));
      step();
      chk("sim_count", 32'(count_o), 32'd2);
    end
    drive(1'b0, 5'd0, 8'd0);
    chk("sim_tail0", 32'(instr_o.dst), 32'd18);
    step();
    chk("sim_tail1", 32'(instr_o.dst), 32'd19);
    step();
    ready_i = 1'b0;
    chk("sim_empty", 32'(empty_o), 32'd1);

    // Flush wins over push and pop in the same cycle
    for (int k = 20; k <= 22; k++) begin
      drive(1'b1, 5'(k), 8'd2);
      step();
    end
    chk("fl_pre_count", 32'(count_o), 32'd3);
    drive(1'b1, 5'd23, 8'd2);
    ready_i = 1'b1;
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    ready_i = 1'b0;
    drive(1'b0, 5'd0, 8'd0);
    chk("fl_count", 32'(count_o), 32'd0);
    chk("fl_valid", 32'(valid_o), 32'd0);
    chk("fl_ready", 32'(ready_o), 32'd1);
    step();
    chk("fl_stay_empty", 32'(valid_o), 32'd0);
    drive(1'b1, 5'd24, 8'd2);
    step();
    drive(1'b0, 5'd0, 8'd0);
    chk("fl_next_head",  32'(instr_o.dst), 32'd24);
    chk("fl_next_count", 32'(count_o), 32'd1);
    ready_i = 1'b1;
    step();
    ready_i = 1'b0;
    chk("fl_next_empty", 32'(empty_o), 32'd1);

    // Asynchronous reset between edges
    drive(1'b1, 5'd30, 8'd3); step();
    drive(1'b1, 5'd31, 8'd3); step();
    drive(1'b0, 5'd0, 8'd0);
    chk("ar_pre_count", 32'(count_o), 32'd2);
    #2;
    rstn_i = 1'b0;
    #1;
    chk("ar_valid_drop", 32'(valid_o), 32'd0);
    chk("ar_count",      32'(count_o), 32'd0);
    chk("ar_ready",      32'(ready_o), 32'd1);
    step();
    rstn_i = 1'b1;
    step();
    drive(1'b1, 5'd7, 8'd4);
    step();
    drive(1'b0, 5'd0, 8'd0);
    chk("ar_new_valid", 32'(valid_o), 32'd1);
    chk("ar_new_dst",   32'(instr_o.dst), 32'd7);
    chk("ar_new_count", 32'(count_o), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
